// File: rtl/score_keeper.sv
// Game score/high-score/round bookkeeping with one shared iterative double-dabble BCD converter.
// Optional macro SCORE_SAT_EN: counters saturate at MAX_VAL instead of wrapping.
module score_keeper #(
   parameter int WIDTH   = 14,
   parameter int MAX_VAL = 9999
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_i,
   input  logic             pause_i,
   input  logic [3:0]       event_i,
   output logic [WIDTH-1:0] score_o,
   output logic [WIDTH-1:0] h_score_o,
   output logic [WIDTH-1:0] rounds_o,
   output logic [15:0]      bcd_score_o,
   output logic [15:0]      bcd_hscore_o,
   output logic [15:0]      bcd_rounds_o,
   output logic             bcd_valid_o,
   output logic             busy_o
);

   localparam int SR_W  = 16 + WIDTH;
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH:0]       MAX_X    = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]       ONE_X    = (WIDTH+1)'(1);
   localparam logic [CNT_W-1:0]     LAST_IT  = CNT_W'(WIDTH - 1);
   localparam logic [1:0]           LAST_SEL = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      STORE,
      DONE
   } state_t;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   // One extra bit in the sum lets a single compare detect the overflow past MAX_VAL.
   function automatic logic [WIDTH-1:0] limit(input logic [WIDTH:0] sum);
`ifdef SCORE_SAT_EN
      return (sum > MAX_X) ? MAX_X[WIDTH-1:0] : sum[WIDTH-1:0];
`else
      logic [WIDTH:0] adj;
      adj = sum - (MAX_X + ONE_X);
      return (sum > MAX_X) ? adj[WIDTH-1:0] : sum[WIDTH-1:0];
`endif
   endfunction

   function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
      logic [SR_W-1:0] t;
      t = v;
      for (int d = 0; d < 4; d++) begin
         if (t[WIDTH+4*d +: 4] >= 4'd5) begin
            t[WIDTH+4*d +: 4] = t[WIDTH+4*d +: 4] + 4'd3;
         end
      end
      return {t[SR_W-2:0], 1'b0};
   endfunction

   // ---------------- counters ----------------
   logic [WIDTH-1:0] score_q, score_d;
   logic [WIDTH-1:0] h_score_q, h_score_d;
   logic [WIDTH-1:0] rounds_q, rounds_d;
   logic [WIDTH:0]   score_sum;
   logic [WIDTH:0]   rounds_sum;
   logic             changed;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      score_d    = score_q;
      h_score_d  = h_score_q;
      rounds_d   = rounds_q;
      score_sum  = {1'b0, score_q} + {{(WIDTH-1){1'b0}}, popcount3(event_i[3:1])};
      rounds_sum = {1'b0, rounds_q} + ONE_X;
      if (tick_i && !pause_i) begin
         if (event_i[0]) begin
            score_d  = '0;
            rounds_d = limit(rounds_sum);
         end else begin
            score_d = limit(score_sum);
`ifndef SCORE_SAT_EN
            // A wrap means the score passed through MAX_VAL on the way.
            if (score_sum > MAX_X) begin
               h_score_d = MAX_X[WIDTH-1:0];
            end
`endif
         end
         if (score_d > h_score_d) begin
            h_score_d = score_d;
         end
      end
   end

   assign changed = (score_d != score_q) || (h_score_d != h_score_q) || (rounds_d != rounds_q);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         score_q   <= '0;
         h_score_q <= '0;
         rounds_q  <= '0;
      end else begin
         score_q   <= score_d;
         h_score_q <= h_score_d;
         rounds_q  <= rounds_d;
      end
   end

   // ---------------- converter ----------------
   state_t           state_q;
   logic             dirty_q;
   logic [1:0]       sel_q;
   logic [CNT_W-1:0] iter_q;
   logic [SR_W-1:0]  shift_q;
   logic [WIDTH-1:0] snap_q [3];
   logic [15:0]      slot_q [3];
   logic [15:0]      bcd_score_q;
   logic [15:0]      bcd_hscore_q;
   logic [15:0]      bcd_rounds_q;
   logic             bcd_valid_q;

   // NOTE: the three slot registers are reset like ordinary flops; they are tiny and feed visible outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dirty_q      <= 1'b0;
         sel_q        <= '0;
         iter_q       <= '0;
         shift_q      <= '0;
         bcd_score_q  <= '0;
         bcd_hscore_q <= '0;
         bcd_rounds_q <= '0;
         bcd_valid_q  <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            snap_q[i] <= '0;
            slot_q[i] <= '0;
         end
      end else begin
         bcd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (dirty_q) begin
                  snap_q[0] <= score_q;
                  snap_q[1] <= h_score_q;
                  snap_q[2] <= rounds_q;
                  dirty_q   <= 1'b0;
                  sel_q     <= '0;
                  state_q   <= LOAD;
               end
            end
            LOAD: begin
               shift_q <= {16'b0, snap_q[sel_q]};
               iter_q  <= '0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               shift_q <= dabble(shift_q);
               iter_q  <= iter_q + 1'b1;
               if (iter_q == LAST_IT) begin
                  state_q <= STORE;
               end
            end
            STORE: begin
               slot_q[sel_q] <= shift_q[SR_W-1 -: 16];
               if (sel_q == LAST_SEL) begin
                  state_q <= DONE;
               end else begin
                  sel_q   <= sel_q + 1'b1;
                  state_q <= LOAD;
               end
            end
            DONE: begin
               bcd_score_q  <= slot_q[0];
               bcd_hscore_q <= slot_q[1];
               bcd_rounds_q <= slot_q[2];
               bcd_valid_q  <= 1'b1;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         // A counter change always wins over the clear at scan start.
         if (changed) begin
            dirty_q <= 1'b1;
         end
      end
   end

   assign score_o      = score_q;
   assign h_score_o    = h_score_q;
   assign rounds_o     = rounds_q;
   assign bcd_score_o  = bcd_score_q;
   assign bcd_hscore_o = bcd_hscore_q;
   assign bcd_rounds_o = bcd_rounds_q;
   assign bcd_valid_o  = bcd_valid_q;
   assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed boundary steps plus random bursts vs. an arithmetic model.
module tb_score_keeper;

   localparam int MAXV = 9999;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_i = 1'b0;
   logic        pause_i = 1'b0;
   logic [3:0]  event_i = 4'b0;
   logic [13:0] score_o, h_score_o, rounds_o;
   logic [15:0] bcd_score_o, bcd_hscore_o, bcd_rounds_o;
   logic        bcd_valid_o, busy_o;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int m_score = 0;
   int m_h = 0;
   int m_rounds = 0;

   score_keeper dut (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (tick_i),
      .pause_i      (pause_i),
      .event_i      (event_i),
      .score_o      (score_o),
      .h_score_o    (h_score_o),
      .rounds_o     (rounds_o),
      .bcd_score_o  (bcd_score_o),
      .bcd_hscore_o (bcd_hscore_o),
      .bcd_rounds_o (bcd_rounds_o),
      .bcd_valid_o  (bcd_valid_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bcd_valid_o) pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // Reference rules applied to one accepted event, in plain integer arithmetic.
   task automatic model_apply(input logic [3:0] ev);
      if (ev[0]) begin
         m_score = 0;
         m_rounds = m_rounds + 1;
      end else begin
         m_score = m_score + $countones(ev[3:1]);
      end
`ifdef SCORE_SAT_EN
      if (m_score > MAXV) m_score = MAXV;
      if (m_rounds > MAXV) m_rounds = MAXV;
`else
      if (m_score > MAXV) begin
         m_score = m_score - (MAXV + 1);
         m_h = MAXV;
      end
      if (m_rounds > MAXV) m_rounds = m_rounds - (MAXV + 1);
`endif
      if (m_score > m_h) m_h = m_score;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] ev);
      tick_i  = 1'b1;
      event_i = ev;
      step();
      if (!pause_i) model_apply(ev);
      tick_i  = 1'b0;
      event_i = 4'b0;
   endtask

   task automatic wait_pulse(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bcd_valid_o && n < 200);
      if (!bcd_valid_o) check("pulse_timeout", 32'(n), 32'd0);
   endtask

   task automatic wait_quiet();
      int idle = 0;
      int n = 0;
      while (idle < 3 && n < 400) begin
         step();
         n++;
         idle = busy_o ? 0 : idle + 1;
      end
      if (idle < 3) check("quiet_timeout", 32'(n), 32'd0);
   endtask

   task automatic check_all(input string tag);
      check({tag, "_score"},  32'(score_o),      32'(m_score));
      check({tag, "_hscore"}, 32'(h_score_o),    32'(m_h));
      check({tag, "_rounds"}, 32'(rounds_o),     32'(m_rounds));
      check({tag, "_bcd_s"},  32'(bcd_score_o),  32'(to_bcd(m_score)));
      check({tag, "_bcd_h"},  32'(bcd_hscore_o), 32'(to_bcd(m_h)));
      check({tag, "_bcd_r"},  32'(bcd_rounds_o), 32'(to_bcd(m_rounds)));
   endtask

   initial begin
      int n;
      int p0;
      int old_s, old_h, old_r;
      logic [3:0] ev;

      // Reset held for two cycles.
      step();
      step();
      check_all("reset");
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_valid", 32'(pulses), 32'd0);
      rst = 1'b0;

      // Reach score 5, then +3 and measure tick-to-bcd_valid latency.
      send(4'b1110);
      send(4'b0110);
      wait_quiet();
      check_all("five");
      send(4'b1110);
      wait_pulse(n);
      check("latency", 32'(n), 32'd50);
      check_all("eight");
      check("eight_bcd", 32'(bcd_score_o), 32'h0008);

      // Robot kill: score clears, rounds advance, dragons ignored.
      send(4'b1011);
      wait_quiet();
      check_all("robot");
      check("robot_bcd_r", 32'(bcd_rounds_o), 32'h0001);

      // Paused tick changes nothing and starts no scan.
      pause_i = 1'b1;
      send(4'b1111);
      pause_i = 1'b0;
      step();
      step();
      check_all("pause");
      check("pause_busy", 32'(busy_o), 32'd0);

      // Event mid-scan: first pulse old snapshot, second pulse new values.
      send(4'b0010);
      old_s = m_score; old_h = m_h; old_r = m_rounds;
      repeat (20) step();
      check("mid_busy", 32'(busy_o), 32'd1);
      send(4'b0110);
      wait_pulse(n);
      check("mid_old_s", 32'(bcd_score_o),  32'(to_bcd(old_s)));
      check("mid_old_h", 32'(bcd_hscore_o), 32'(to_bcd(old_h)));
      check("mid_old_r", 32'(bcd_rounds_o), 32'(to_bcd(old_r)));
      wait_pulse(n);
      check_all("mid_new");

      // Climb to 9998 and cross the MAX_VAL boundary.
      while (m_score + 3 <= 9998) send(4'b1110);
      if (m_score == 9997) send(4'b0010);
      else if (m_score == 9996) send(4'b0110);
      wait_quiet();
      check_all("at9998");
      send(4'b0110);
      wait_quiet();
      check_all("boundary");
      send(4'b1110);
      wait_quiet();
      check_all("after_boundary");

      // Random bursts, compared once the converter has settled.
      for (int r = 0; r < 40; r++) begin
         for (int k = 0; k < 1 + $urandom_range(0, 29); k++) begin
            ev      = 4'($urandom);
            if ($urandom_range(0, 7) == 0) ev[0] = 1'b1;
            else ev[0] = 1'b0;
            pause_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) send(ev);
            else step();
         end
         pause_i = 1'b0;
         wait_quiet();
         check_all("rand");
      end

      // Reset in the middle of a scan: abort, zero outputs, no pulse.
      send(4'b0100);
      repeat (10) step();
      p0 = pulses;
      rst = 1'b1;
      step();
      m_score = 0; m_h = 0; m_rounds = 0;
      check("rst_mid_busy", 32'(busy_o), 32'd0);
      check_all("rst_mid");
      rst = 1'b0;
      repeat (80) step();
      check("rst_mid_nopulse", 32'(pulses), 32'(p0));
      check("rst_mid_idle", 32'(busy_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
